// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: two-master round-robin Wishbone arbiter with a stalled-access watchdog
module wb_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255,
  parameter int TW = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      gnt_o,
  output logic            timeout_o
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  localparam logic [TW-1:0] LIM = TW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  state_t state, nxt;
  logic last_served, to_pulse, stall, fire, g0, g1;
  logic [TW-1:0] cnt;
  always_comb begin
    nxt = state;
    if (state == IDLE)
      nxt = (m0_cyc_i && (!m1_cyc_i || last_served)) ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
    else if (state == GNT0 && !m0_cyc_i)
      nxt = m1_cyc_i ? GNT1 : IDLE;
    else if (state == GNT1 && !m1_cyc_i)
      nxt = m0_cyc_i ? GNT0 : IDLE;
  end
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  assign gnt_o = {g1, g0};
  assign timeout_o = to_pulse;
  assign s_cyc_o = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
  assign s_stb_o = (g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0) & ~to_pulse;
  assign s_we_o  = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
  assign s_adr_o = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
  assign s_dat_o = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
  assign s_sel_o = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
  assign m0_dat_o = g0 ? s_dat_i : '0;
  assign m1_dat_o = g1 ? s_dat_i : '0;
  assign m0_ack_o = g0 & s_ack_i;
  assign m1_ack_o = g1 & s_ack_i;
  assign m0_err_o = g0 & (s_err_i | to_pulse);
  assign m1_err_o = g1 & (s_err_i | to_pulse);
  assign stall = s_stb_o & ~s_ack_i & ~s_err_i;
  // a fire across a grant change would hit the wrong master, so it waits for a stable state
  assign fire = (TIMEOUT != 0) && stall && cnt == LIM && nxt == state;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      last_served <= 1'b1;
      cnt <= '0;
      to_pulse <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state && nxt != IDLE) last_served <= nxt == GNT1;
      to_pulse <= fire;
      cnt <= (!stall || nxt != state || fire) ? '0 : (&cnt) ? cnt : cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: directed checks of grant, handoff, locking, reset and watchdog
module tb_wb_bus_arbiter;
  logic clk = 0, rst = 1;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m0_adr = 0, m0_dat = 0, m1_adr = 0, m1_dat = 0, s_dat = 0;
  logic [3:0] m0_sel = 0, m1_sel = 0;
  logic s_ack = 0, s_err = 0;
  logic [31:0] m0_rd, m1_rd, sa, sd, n_m0_rd, n_m1_rd, n_sa, n_sd;
  logic m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we, to;
  logic n_m0_ack, n_m0_err, n_m1_ack, n_m1_err, n_s_cyc, n_s_stb, n_s_we, n_to;
  logic [3:0] ss, n_ss;
  logic [1:0] gnt, n_gnt;
  int tests = 0, fails = 0;
  bit nt_err, nt_to;

  always #5 clk = ~clk;

  wb_bus_arbiter #(.TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_rd), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_rd), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(sa), .s_dat_o(sd), .s_sel_o(ss),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .gnt_o(gnt), .timeout_o(to));

  wb_bus_arbiter #(.TIMEOUT(0)) dut_nt (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(n_m0_rd), .m0_ack_o(n_m0_ack), .m0_err_o(n_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(n_m1_rd), .m1_ack_o(n_m1_ack), .m1_err_o(n_m1_err),
    .s_cyc_o(n_s_cyc), .s_stb_o(n_s_stb), .s_we_o(n_s_we), .s_adr_o(n_sa), .s_dat_o(n_sd), .s_sel_o(n_ss),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .gnt_o(n_gnt), .timeout_o(n_to));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) step();
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_scyc", s_cyc, 0);
    chk("rst_to", to, 0);
    rst = 0;
    // single master read with two wait states
    step();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10; m0_sel = 4'hf;
    #1 chk("sm_gnt_pre", gnt, 0);
    step();
    #1 chk("sm_gnt", gnt, 2'b01);
    chk("sm_scyc", s_cyc, 1);
    chk("sm_sadr", sa, 32'h10);
    chk("sm_sstb", s_stb, 1);
    step();
    #1 chk("sm_wait_ack", m0_ack, 0);
    step();
    s_ack = 1; s_dat = 32'hDEADBEEF;
    #1 chk("sm_ack", m0_ack, 1);
    chk("sm_dat", m0_rd, 32'hDEADBEEF);
    chk("sm_m1_ack", m1_ack, 0);
    chk("sm_m1_dat", m1_rd, 0);
    step();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1 chk("sm_ack_once", m0_ack, 0);
    step();
    #1 chk("sm_idle", gnt, 0);
    chk("sm_idle_cyc", s_cyc, 0);
    // asynchronous reset in the middle of an m1 transfer
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
    step();
    s_ack = 1;
    #1 chk("rs_m1_ack_pre", m1_ack, 1);
    rst = 1;
    #1 chk("rs_gnt", gnt, 0);
    chk("rs_scyc", s_cyc, 0);
    chk("rs_m1_ack", m1_ack, 0);
    repeat (5) step();
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    rst = 0;
    step();
    #1 chk("rs_idle", gnt, 0);
    // tie and round-robin handoff m0 -> m1 -> m0
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
    step();
    s_ack = 1;
    #1 chk("rr_first", gnt, 2'b01);
    chk("rr_first_adr", sa, 32'h100);
    chk("rr_first_ack", m0_ack, 1);
    step();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    #1 chk("rr_hold0", gnt, 2'b01);
    step();
    m0_cyc = 1; m0_stb = 1; s_ack = 1;
    #1 chk("rr_second", gnt, 2'b10);
    chk("rr_second_adr", sa, 32'h200);
    chk("rr_second_ack", m1_ack, 1);
    chk("rr_second_m0ack", m0_ack, 0);
    step();
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    #1 chk("rr_hold1", gnt, 2'b10);
    step();
    #1 chk("rr_third", gnt, 2'b01);
    chk("rr_third_adr", sa, 32'h100);
    m0_cyc = 0; m0_stb = 0;
    step();
    step();
    #1 chk("rr_idle", gnt, 0);
    // m1 locks the bus for a 4-beat burst while m0 waits
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      s_ack = 1;
      #1 chk($sformatf("lk_gnt%0d", i), gnt, 2'b10);
      chk($sformatf("lk_ack%0d", i), m1_ack, 1);
      chk($sformatf("lk_m0ack%0d", i), m0_ack, 0);
      step();
    end
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    #1 chk("lk_hold", gnt, 2'b10);
    step();
    #1 chk("lk_switch", gnt, 2'b01);
    m0_cyc = 0; m0_stb = 0;
    step();
    step();
    // watchdog with TIMEOUT = 8
    m0_cyc = 1; m0_stb = 1;
    step();
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("wd_err%0d", k), m0_err, 0);
      step();
    end
    #1 chk("wd_err", m0_err, 1);
    chk("wd_to", to, 1);
    chk("wd_stb", s_stb, 0);
    step();
    #1 chk("wd_err_clr", m0_err, 0);
    chk("wd_to_clr", to, 0);
    m0_cyc = 0; m0_stb = 0;
    step();
    m1_cyc = 1; m1_stb = 1;
    step();
    s_ack = 1; s_dat = 32'h12345678;
    #1 chk("wd_m1_ack", m1_ack, 1);
    chk("wd_m1_err", m1_err, 0);
    chk("wd_m1_dat", m1_rd, 32'h12345678);
    step();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    step();
    step();
    // watchdog disabled: 1000-cycle stall then an ack
    m0_cyc = 1; m0_stb = 1;
    step();
    nt_err = 0; nt_to = 0;
    for (int k = 0; k < 1000; k++) begin
      #1 nt_err |= n_m0_err;
      nt_to |= n_to;
      step();
    end
    chk("nt_no_err", nt_err, 0);
    chk("nt_no_to", nt_to, 0);
    chk("nt_gnt", n_gnt, 2'b01);
    s_ack = 1;
    #1 chk("nt_ack", n_m0_ack, 1);
    chk("nt_ack_err", n_m0_err, 0);
    chk("nt_m1_ack", n_m1_ack, 0);
    step();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1 chk("nt_ack_once", n_m0_ack, 0);
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter for the SOPC bus.
- Shares the single system bus between the OR1200 instruction master (m0) and data master (m1).
- Round-robin grant; a granted master keeps the bus for as long as its cyc stays high.
- A bus watchdog converts a stalled slave access into an error response to the granted master.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 255, stalled-strobe cycles before the watchdog fires; 0 disables the watchdog.
- TW, 8, watchdog counter width; TIMEOUT must be less than 2^TW.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle, strobe, write enable.
- m0_adr_i  in  AW  master 0 address.
- m0_dat_i  in  DW  master 0 write data.
- m0_sel_i  in  DW/8  master 0 byte selects.
- m0_dat_o  out  DW  read data to master 0.
- m0_ack_o, m0_err_o  out  1 each  acknowledge and error to master 0.
- m1_*  same set as m0_*, for master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side cycle, strobe, write enable.
- s_adr_o  out  AW  slave-side address.
- s_dat_o  out  DW  slave-side write data.
- s_sel_o  out  DW/8  slave-side byte selects.
- s_dat_i  in  DW  slave read data.
- s_ack_i, s_err_i  in  1 each  slave acknowledge and error.
- gnt_o  out  2  one-hot grant: bit0 = m0, bit1 = m1.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state IDLE, gnt_o = 00, last_served = m1 (so m0 wins the first tie).
  - watchdog count = 0, timeout_o = 0.
  - All s_* outputs and all m*_ack_o / m*_err_o = 0; m*_dat_o = 0.
  - Applies mid-transfer as well; no partial ack is issued after reset.
- FSM states: IDLE, GNT0, GNT1. gnt_o is decoded from the state register.
- IDLE:
  - Only m0_cyc_i high -> GNT0. Only m1_cyc_i high -> GNT1.
  - Both high -> the master that is not last_served.
  - Grant latency: cyc sampled high on edge N; s_cyc_o follows from cycle N+1.
- GNTx:
  - Slave outputs are a combinational mux of master x's inputs: s_cyc_o = mx_cyc_i, s_stb_o = mx_stb_i & ~to_pulse, and the same for we, adr, dat, sel.
  - mx_dat_o = s_dat_i; mx_ack_o = s_ack_i; mx_err_o = s_err_i | to_pulse.
  - The non-granted master sees ack = err = 0 and dat = 0.
  - last_served <= x on entry.
- Release:
  - In GNTx, with mx_cyc_i sampled low: next state is GNTy if my_cyc_i is high (direct handoff, no idle gap), otherwise IDLE.
  - Grant is never revoked while mx_cyc_i stays high, so block and RMW cycles are atomic.
- In IDLE, all s_* outputs = 0.
- Watchdog:
  - A stall is s_stb_o & ~s_ack_i & ~s_err_i. Each stalled cycle increments the count.
  - The count clears on any cycle with ack/err, with s_stb_o low, or on a state change.
  - On a stalled cycle with count == TIMEOUT-1, to_pulse is registered high for exactly one cycle.
  - During to_pulse: the granted master sees err = 1, s_stb_o is forced 0, timeout_o = 1, and the count clears.
  - With stb asserted in cycle 0 and no response, err appears in cycle TIMEOUT.
  - If TIMEOUT = 0, to_pulse never asserts.
- Simultaneous events:
  - A slave ack in the same cycle to_pulse is set is not possible, because the count clears on ack.
  - A slave ack landing in the to_pulse cycle is still passed through; err and ack are then both high, and the master treats err as dominant.
- Counter: width TW, saturating; no wrap-around is possible because it clears at TIMEOUT-1.

Test Plan:
- Reset: rst_i pulsed for 5 cycles mid-transfer in GNT1 -> gnt_o = 00, s_cyc_o = 0, and m1_ack_o = 0 immediately; after release, IDLE.
- Single master: m0 issues a read of address 0x00000010, slave acks after 2 wait states with data 0xDEADBEEF -> gnt_o = 01 one cycle after cyc, m0_dat_o = 0xDEADBEEF with m0_ack_o high for 1 cycle, m1_ack_o = 0.
- Tie and round-robin: m0 and m1 raise cyc in the same cycle, three times in succession -> grant order m0, m1, m0; direct handoff with no IDLE cycle between grants.
- Lock: m1 holds cyc for a 4-beat burst while m0 requests -> gnt_o stays 10 for all 4 acks; switches to 01 on the cycle after m1 drops cyc.
- Timeout with TIMEOUT = 8: m0 strobes and the slave never acks -> m0_err_o = 1 and timeout_o = 1 in cycle 8, s_stb_o = 0 in that cycle; a later m1 access completes normally.
- Timeout disabled with TIMEOUT = 0: the slave stalls for 1000 cycles then acks -> no err, single ack delivered to the granted master.
